// File: rtl/clic_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : clic_pkg
//  Description : Shared types, constants and the CSR read-modify-write helper
//                for the n_clic_ext interrupt controller.
//                  csr_op_t  - CSRRW/S/C and their immediate forms
//                  entry_t   - per-vector control entry (pended at the LSB)
//                  stack_t   - one EPC/threshold stack frame
//                  status_t  - read-only status CSR layout
//  Revision    : 1.0 - initial release
// ============================================================================
package clic_pkg;

  localparam int unsigned PRIO_LEVELS = 8;
  localparam int unsigned PRIO_WIDTH  = $clog2(PRIO_LEVELS);
  localparam int unsigned IMEM_AW     = 16;
  localparam int unsigned VEC_W       = IMEM_AW - 2;

  // A PC of all ones from the core means "return from interrupt".
  localparam logic [IMEM_AW-1:0] RetAddr = '1;

  typedef enum logic [2:0] {
    CSR_RW  = 3'b001,
    CSR_RS  = 3'b010,
    CSR_RC  = 3'b011,
    CSR_RWI = 3'b101,
    CSR_RSI = 3'b110,
    CSR_RCI = 3'b111
  } csr_op_t;

  // Packed MSB first, so pended lands at bit 0 of the CSR image.
  typedef struct packed {
    logic [PRIO_WIDTH-1:0] prio;
    logic                  trig;     // 0 = level, 1 = edge
    logic                  enabled;
    logic                  pended;
  } entry_t;

  localparam int unsigned ENTRY_W = $bits(entry_t);

  typedef struct packed {
    logic [IMEM_AW-1:0]    addr;
    logic [PRIO_WIDTH-1:0] prio;
  } stack_t;

  typedef struct packed {
    logic [21:0] rsvd;
    logic        udf;
    logic        ovf;
    logic [7:0]  level;
  } status_t;

  // New CSR value for a read-modify-write op; bit 2 of the op selects the
  // zero-extended 5-bit immediate as the source operand.
  function automatic logic [31:0] csr_apply(input csr_op_t     op,
                                            input logic [31:0] old_val,
                                            input logic [31:0] rs1_val,
                                            input logic [4:0]  zimm);
    logic [2:0]  op_bits;
    logic [31:0] src;
    op_bits = op;
    src     = op_bits[2] ? {27'b0, zimm} : rs1_val;
    case (op_bits[1:0])
      2'b01:   csr_apply = src;
      2'b10:   csr_apply = old_val | src;
      2'b11:   csr_apply = old_val & ~src;
      default: csr_apply = old_val;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/clic_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : clic_arbiter
//  Description : Purely combinational winner selection over the registered
//                interrupt entries. A candidate qualifies when it is enabled,
//                pended and its priority is strictly above the threshold.
//                Highest priority wins; ties go to the lowest index.
//  Ports       : entries_i  - all vector entries
//                thresh_i   - current interrupt threshold
//                is_int_o   - some candidate qualifies
//                win_idx_o  - index of the winner (0 when none)
//                win_prio_o - priority of the winner (0 when none)
//  Revision    : 1.0 - initial release
// ============================================================================
module clic_arbiter
  import clic_pkg::*;
#(
  parameter int unsigned VecSize = 16,
  parameter int unsigned IdxW    = (VecSize > 1) ? $clog2(VecSize) : 1
) (
  input  entry_t [VecSize-1:0]  entries_i,
  input  logic [PRIO_WIDTH-1:0] thresh_i,
  output logic                  is_int_o,
  output logic [IdxW-1:0]       win_idx_o,
  output logic [PRIO_WIDTH-1:0] win_prio_o
);

  always_comb begin
    is_int_o   = 1'b0;
    win_idx_o  = '0;
    win_prio_o = '0;
    // Ascending scan with a strict '>' keeps the lowest index on a tie.
    for (int k = 0; k < VecSize; k++) begin
      if (entries_i[k].enabled && entries_i[k].pended &&
          (entries_i[k].prio > thresh_i) &&
          (!is_int_o || (entries_i[k].prio > win_prio_o))) begin
        is_int_o   = 1'b1;
        win_idx_o  = IdxW'(k);
        win_prio_o = entries_i[k].prio;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/n_clic_ext.sv
`default_nettype none
// ============================================================================
//  Module      : n_clic_ext
//  Description : Core-local interrupt controller with per-vector level/edge
//                triggering, hardware pend-clear on take, nesting through an
//                EPC/threshold stack, tail-chaining on return and sticky stack
//                overflow/underflow flags.
//  Ports       : clk, reset         - clock, synchronous active-high reset
//                csr_enable         - CSR instruction valid
//                csr_addr           - CSR address
//                rs1_zimm, rs1_data - immediate / register source operand
//                csr_op             - CSR read-modify-write operation
//                irq_in             - interrupt lines, synchronous to clk
//                pc_in              - next PC from core (all ones = return)
//                pc_out             - redirected PC
//                out                - combinational CSR read data
//  Revision    : 1.0 - initial release
// ============================================================================
module n_clic_ext
  import clic_pkg::*;
#(
  parameter int unsigned VecSize        = 16,
  parameter int unsigned StackDepth     = 8,
  parameter logic [11:0] VecCsrBase     = 12'hb00,
  parameter logic [11:0] EntryCsrBase   = 12'hb20,
  parameter logic [11:0] MIntThreshAddr = 12'h347,
  parameter logic [11:0] StatusAddr     = 12'h350
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               csr_enable,
  input  logic [11:0]        csr_addr,
  input  logic [4:0]         rs1_zimm,
  input  logic [31:0]        rs1_data,
  input  csr_op_t            csr_op,
  input  logic [VecSize-1:0] irq_in,
  input  logic [IMEM_AW-1:0] pc_in,
  output logic [IMEM_AW-1:0] pc_out,
  output logic [31:0]        out
);

  localparam int unsigned IDX_W = (VecSize > 1) ? $clog2(VecSize) : 1;
  localparam int unsigned LVL_W = $clog2(StackDepth + 1);
  localparam int unsigned PTR_W = (StackDepth > 1) ? $clog2(StackDepth) : 1;
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(StackDepth);
  localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  entry_t [VecSize-1:0]            entry_q, entry_d;
  logic   [VecSize-1:0][VEC_W-1:0] vec_q, vec_d;
  logic   [VecSize-1:0]            irq_dly_q;
  logic   [PRIO_WIDTH-1:0]         thresh_q, thresh_d;
  logic   [LVL_W-1:0]              sp_q, sp_d;
  logic                            ovf_q, ovf_d;
  logic                            udf_q, udf_d;
  stack_t                          stack_q [StackDepth];

  // --------------------------------------------------------------------------
  // Arbitration and per-cycle decision
  // --------------------------------------------------------------------------
  logic                  is_int;
  logic [IDX_W-1:0]      win_idx;
  logic [PRIO_WIDTH-1:0] win_prio;

  clic_arbiter #(
    .VecSize (VecSize),
    .IdxW    (IDX_W)
  ) u_arbiter (
    .entries_i  (entry_q),
    .thresh_i   (thresh_q),
    .is_int_o   (is_int),
    .win_idx_o  (win_idx),
    .win_prio_o (win_prio)
  );

  logic   is_ret, do_tail, do_take, do_rtn;
  logic   stk_full, stk_empty, clr_en;
  stack_t stk_top;

  assign is_ret    = (pc_in == RetAddr);
  // Reset suppresses every decision so a reset mid-nesting never redirects.
  assign do_tail   = !reset &&  is_ret &&  is_int;
  assign do_take   = !reset && !is_ret &&  is_int;
  assign do_rtn    = !reset &&  is_ret && !is_int;
  assign stk_full  = (sp_q == LVL_FULL);
  assign stk_empty = (sp_q == '0);
  assign stk_top   = stack_q[PTR_W'(sp_q - LVL_ONE)];
  // Only edge-mode winners lose their pend; level sources stay pended.
  assign clr_en    = (do_tail || do_take) && entry_q[win_idx].trig;

  always_comb begin
    pc_out = pc_in;
    if (do_tail || do_take) begin
      pc_out = {vec_q[win_idx], 2'b00};
    end else if (do_rtn) begin
      pc_out = stk_empty ? '0 : stk_top.addr;
    end
  end

  // --------------------------------------------------------------------------
  // Vector and entry next state. Pended precedence: hardware set, then
  // take-clear, then the CSR write (applied first so later lines override).
  // --------------------------------------------------------------------------
  logic [VecSize-1:0] hw_set;

  always_comb begin
    entry_d = entry_q;
    vec_d   = vec_q;
    hw_set  = '0;
    for (int k = 0; k < VecSize; k++) begin
      if (csr_enable && (csr_addr == VecCsrBase + 12'(k))) begin
        vec_d[k] = VEC_W'(csr_apply(csr_op, 32'(vec_q[k]), rs1_data, rs1_zimm));
      end
      if (csr_enable && (csr_addr == EntryCsrBase + 12'(k))) begin
        entry_d[k] = entry_t'(ENTRY_W'(csr_apply(csr_op, 32'(entry_q[k]),
                                                 rs1_data, rs1_zimm)));
      end
      hw_set[k] = entry_q[k].trig ? (irq_in[k] & ~irq_dly_q[k]) : irq_in[k];
      if (hw_set[k]) begin
        entry_d[k].pended = 1'b1;
      end else if (clr_en && (win_idx == IDX_W'(k))) begin
        entry_d[k].pended = 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Threshold, stack pointer and sticky flags
  // --------------------------------------------------------------------------
  always_comb begin
    thresh_d = thresh_q;
    sp_d     = sp_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    if (do_take) begin
      thresh_d = win_prio;
      if (stk_full) begin
        ovf_d = 1'b1;
      end else begin
        sp_d = sp_q + LVL_ONE;
      end
    end else if (do_rtn) begin
      if (stk_empty) begin
        udf_d    = 1'b1;
        thresh_d = '0;
      end else begin
        sp_d     = sp_q - LVL_ONE;
        thresh_d = stk_top.prio;
      end
    end else if (!do_tail && csr_enable && (csr_addr == MIntThreshAddr)) begin
      // Software may only move the threshold when hardware is not.
      thresh_d = PRIO_WIDTH'(csr_apply(csr_op, 32'(thresh_q), rs1_data, rs1_zimm));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      entry_q   <= '0;
      vec_q     <= '0;
      irq_dly_q <= '0;
      thresh_q  <= '0;
      sp_q      <= '0;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
    end else begin
      entry_q   <= entry_d;
      vec_q     <= vec_d;
      irq_dly_q <= irq_in;
      thresh_q  <= thresh_d;
      sp_q      <= sp_d;
      ovf_q     <= ovf_d;
      udf_q     <= udf_d;
    end
  end

  // Stack contents need no reset: the level counter defines what is valid.
  always_ff @(posedge clk) begin
    if (do_take && !stk_full) begin
      stack_q[PTR_W'(sp_q)] <= '{addr: pc_in, prio: thresh_q};
    end
  end

  // --------------------------------------------------------------------------
  // CSR read mux
  // --------------------------------------------------------------------------
  status_t status;

  always_comb begin
    status       = '0;
    status.level = 8'(sp_q);
    status.ovf   = ovf_q;
    status.udf   = udf_q;

    out = '0;
    if (csr_addr == MIntThreshAddr) begin
      out = 32'(thresh_q);
    end else if (csr_addr == StatusAddr) begin
      out = status;
    end
    for (int k = 0; k < VecSize; k++) begin
      if (csr_addr == VecCsrBase + 12'(k)) begin
        out = 32'(vec_q[k]);
      end
      if (csr_addr == EntryCsrBase + 12'(k)) begin
        out = 32'(entry_q[k]);
      end
    end
  end

endmodule
`default_nettype wire
